// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, synchronous flush, control zeroed on bubbles.
// Define PIPE_STAGE_SKID_EN for a skid entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 134,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_v_q, m_v_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_fire_c, out_fire_c;

`ifdef PIPE_STAGE_SKID_EN
  logic              s_v_q, s_v_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
`else
  assign in_ready = !m_v_q | out_ready;
`endif

  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = m_v_q & out_ready;

  assign out_valid = m_v_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q & {CTRL_W{m_v_q}};
  assign stall_cnt = cnt_q;

  // Next-state: EMPTY/ONE/TWO are encoded directly by the entry valid bits.
  always_comb begin
    m_v_d    = m_v_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
`ifdef PIPE_STAGE_SKID_EN
    s_v_d    = s_v_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
`endif
    if (flush) begin
      m_v_d = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      s_v_d = 1'b0;
`endif
    end else if (!m_v_q) begin
      if (in_fire_c) begin
        m_v_d    = 1'b1;
        m_ctrl_d = in_ctrl;
        m_data_d = in_data;
      end
`ifdef PIPE_STAGE_SKID_EN
    end else if (s_v_q) begin
      if (out_fire_c) begin
        m_ctrl_d = s_ctrl_q;
        m_data_d = s_data_q;
        s_v_d    = 1'b0;
      end
    end else if (in_fire_c && !out_fire_c) begin
      s_v_d    = 1'b1;
      s_ctrl_d = in_ctrl;
      s_data_d = in_data;
`endif
    end else if (in_fire_c) begin
      m_ctrl_d = in_ctrl;
      m_data_d = in_data;
    end else if (out_fire_c) begin
      m_v_d = 1'b0;
    end

`ifdef PIPE_STAGE_SKID_EN
    in_ready_d = !(m_v_d & s_v_d);
`endif

    cnt_d = cnt_q;
    if (m_v_q && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v_q      <= 1'b0;
      m_ctrl_q   <= '0;
      m_data_q   <= '0;
      cnt_q      <= '0;
`ifdef PIPE_STAGE_SKID_EN
      s_v_q      <= 1'b0;
      s_ctrl_q   <= '0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
`endif
    end else begin
      m_v_q      <= m_v_d;
      m_ctrl_q   <= m_ctrl_d;
      m_data_q   <= m_data_d;
      cnt_q      <= cnt_d;
`ifdef PIPE_STAGE_SKID_EN
      s_v_q      <= s_v_d;
      s_ctrl_q   <= s_ctrl_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a FIFO reference model.
module tb_pipe_stage_reg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned DATA_W = 134;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  int tests = 0;
  int fails = 0;

  beat_t       q[$];
  int unsigned mcnt = 0;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: checks outputs at mid-cycle, then advances the model across the edge.
  task automatic step();
    logic exp_ir, infire, outfire;
    beat_t b;
    #4;
    exp_ir = (CAP == 2) ? (q.size() < 2) : ((q.size() == 0) || out_ready);
    chk("in_ready", 256'(in_ready), 256'(exp_ir));
    chk("out_valid", 256'(out_valid), 256'(q.size() > 0));
    chk("out_ctrl", 256'(out_ctrl), (q.size() > 0) ? 256'(q[0].ctrl) : 256'(0));
    if (q.size() > 0) chk("out_data", 256'(out_data), 256'(q[0].data));
    chk("stall_cnt", 256'(stall_cnt), 256'(mcnt));
    infire  = in_valid & exp_ir;
    outfire = (q.size() > 0) & out_ready;
    b.ctrl = in_ctrl;
    b.data = in_data;
    @(posedge clk);
    if ((q.size() > 0) && !out_ready && (mcnt != CNT_MAX)) mcnt++;
    if (flush) q.delete();
    else begin
      if (outfire) void'(q.pop_front());
      if (infire) q.push_back(b);
    end
    #1;
  endtask

  task automatic drv(input logic iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                     input logic fl, input logic ordy);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    q.delete();
    mcnt = 0;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_ctrl", 256'(out_ctrl), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    chk("rst_stall_cnt", 256'(stall_cnt), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset then stream 8 beats with full throughput
    do_reset();
    for (int i = 0; i < 8; i++) drv(1'b1, 16'hFFFF, DATA_W'(i), 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) drv(1'b0, 16'h0000, '0, 1'b0, 1'b1);
    chk("stream_stall_zero", 256'(stall_cnt), 256'(0));

    // Backpressure: A accepted, stall, offer B, then drain
    drv(1'b1, 16'h00A5, DATA_W'(32'h11), 1'b0, 1'b0);
    drv(1'b1, 16'h005A, DATA_W'(32'h22), 1'b0, 1'b0);
    drv(1'b0, 16'h0000, '0, 1'b0, 1'b0);
    drv(1'b0, 16'h0000, '0, 1'b0, 1'b1);
    drv(1'b0, 16'h0000, '0, 1'b0, 1'b1);
    drv(1'b0, 16'h0000, '0, 1'b0, 1'b1);

    // Bubble masking with control bits held high
    for (int i = 0; i < 4; i++) drv(1'b0, 16'hFFFF, DATA_W'(32'hDEAD), 1'b0, 1'b1);

    // Flush collision: hold A and B (where a skid exists), flush while offering C
    drv(1'b1, 16'h1111, DATA_W'(32'hAA), 1'b0, 1'b0);
    drv(1'b1, 16'h2222, DATA_W'(32'hBB), 1'b0, 1'b0);
    drv(1'b1, 16'h3333, DATA_W'(32'hCC), 1'b1, 1'b0);
    chk("flush_out_valid", 256'(out_valid), 256'(0));
    chk("flush_in_ready", 256'(in_ready), 256'(1));
    for (int i = 0; i < 3; i++) drv(1'b0, 16'h0000, '0, 1'b0, 1'b1);

    // Stall saturation, survives flush, cleared by reset
    drv(1'b1, 16'h0F0F, DATA_W'(32'h55), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drv(1'b0, 16'h0000, '0, 1'b0, 1'b0);
    chk("sat_stall", 256'(stall_cnt), 256'(CNT_MAX));
    drv(1'b0, 16'h0000, '0, 1'b1, 1'b0);
    drv(1'b0, 16'h0000, '0, 1'b0, 1'b0);
    chk("sat_after_flush", 256'(stall_cnt), 256'(CNT_MAX));
    do_reset();
    chk("sat_after_rst", 256'(stall_cnt), 256'(0));

    // Async reset between edges while a beat is held
    drv(1'b1, 16'hFFFF, DATA_W'(32'h77), 1'b0, 1'b0);
    chk("one_out_valid", 256'(out_valid), 256'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 256'(out_valid), 256'(0));
    chk("async_out_ctrl", 256'(out_ctrl), 256'(0));
    q.delete();
    mcnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drv(($urandom_range(0, 3) != 0),
          CTRL_W'($urandom),
          DATA_W'({$urandom, $urandom, $urandom, $urandom, $urandom}),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 3; i++) drv(1'b0, 16'h0000, '0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
